// File: rtl/kbd_responder.sv
// PS/2 keyboard receiver with E0/F0 prefix folding, a code FIFO and a one-read-per-access MMU response port.
// Response is registered one cycle after kbd_en is seen; the PS/2 side has no backpressure and a full FIFO drops the entry and sets ovf.
module kbd_responder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          kbd_en,
  output logic [15:0]                   kbd_respond,
  output logic                          kbd_r_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  logic            clk_s1, clk_s2, clk_h;
  logic            dat_s1, dat_s2;
  logic            fall;

  rx_state_t       state, state_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            par, par_nxt;
  logic [TW-1:0]   to_cnt, to_nxt;
  logic            byte_ok, byte_bad;

  logic            ext, brk, ovf;
  logic            push_req, do_push, pop, ovf_set;
  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [9:0]      head;
  logic            empty, full;

  logic            en_r, en_rr, rd_trig;

  // Synchronisers idle high so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_h  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_h  <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_h & ~clk_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      par     <= par_nxt;
      to_cnt  <= to_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_nxt     = par;
    to_nxt      = '0;
    byte_ok     = 1'b0;
    byte_bad    = 1'b0;
    if (state != S_IDLE && !fall) begin
      to_nxt = to_cnt + TW'(1);
      if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state_nxt = S_IDLE;
        to_nxt    = '0;
      end
    end else if (fall) begin
      case (state)
        S_IDLE: begin
          if (!dat_s2) begin
            state_nxt   = S_DATA;
            bit_cnt_nxt = '0;
          end
        end
        S_DATA: begin
          shift_nxt   = {dat_s2, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        end
        S_PARITY: begin
          par_nxt   = dat_s2;
          state_nxt = S_STOP;
        end
        S_STOP: begin
          if (dat_s2 && (^{shift, par})) byte_ok = 1'b1;
          else                           byte_bad = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign push_req = byte_ok && (shift != 8'hE0) && (shift != 8'hF0);

  // A bad frame also discards any pending prefix so a half-seen sequence cannot leak into the next key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= byte_bad;
      if (byte_bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_ok) begin
        if (shift == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

  assign empty   = (fifo_count == '0);
  assign full    = (fifo_count == CW'(FIFO_DEPTH));
  assign rd_trig = en_r & ~en_rr;
  assign pop     = rd_trig & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is kept in that cycle.
  assign do_push = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {brk, ext, shift};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf        <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (ovf_set)      ovf <= 1'b1;
      else if (rd_trig) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r        <= 1'b0;
      en_rr       <= 1'b0;
      kbd_respond <= 16'h0000;
      kbd_r_ready <= 1'b0;
    end else begin
      en_r  <= kbd_en;
      en_rr <= en_r;
      if (rd_trig) begin
        kbd_r_ready <= 1'b1;
        if (empty) kbd_respond <= {3'b000, ovf, 12'h000};
        else       kbd_respond <= {1'b1, head[9], head[8], ovf, 4'b0000, head[7:0]};
      end else if (!kbd_en) begin
        kbd_r_ready <= 1'b0;
        kbd_respond <= 16'h0000;
      end
    end
  end

endmodule

// File: doc/kbd_responder.md
# kbd_responder

PS/2 keyboard device that answers the keyboard read path of the memory-mapped device segment. It has three stages:
- Deserialises PS/2 frames from the keyboard pins.
- Folds the `E0`/`F0` prefix bytes into flags.
- Queues the decoded codes in a FIFO.

It returns one queued entry per CPU read access via the `kbd_en` / `kbd_respond` / `kbd_r_ready` handshake. The block sits between the board PS/2 pins and the MMU keyboard read port.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: queue entries; must be a power of 2, ≥ 2.
- `TIMEOUT_CYCLES`, default 20000: idle `clk` cycles mid-frame before the receiver aborts the frame.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `ps2_clk`, in, 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`, in, 1: raw PS/2 data, asynchronous to `clk`.
- `kbd_en`, in, 1: read access to the keyboard address; level, may stay high several cycles.
- `kbd_respond`, out, 16: read data.
- `kbd_r_ready`, out, 1: read data valid.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- `frame_err`, out, 1: one-cycle pulse on a discarded frame (parity or stop error).

## Operation
- **Synchroniser:** `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. One extra history flop on the synchronised clock gives edge detection. A falling edge is history=1 and sync=0. Data is sampled from the synchronised `ps2_data` in the same cycle.
- **Receiver FSM:** states IDLE, DATA, PARITY, STOP. All transitions happen only on a falling edge, except timeout.
  - IDLE: data=0 (start bit) → DATA with bit counter 0. Data=1 → stay in IDLE.
  - DATA: shift the bit in LSB-first; after the 8th bit → PARITY.
  - PARITY: latch the bit → STOP.
  - STOP: data=1 and odd parity over 8 data bits plus parity bit → accept byte, then IDLE. Otherwise → pulse `frame_err`, clear the prefix flags, then IDLE.
  - Timeout: the counter resets on every falling edge. In any non-IDLE state, reaching `TIMEOUT_CYCLES` → IDLE, partial byte discarded, no `frame_err`, prefix flags kept.
- **Prefix decoding of accepted bytes:**
  - `8'hE0` sets `ext`; `8'hF0` sets `brk`. Neither is pushed.
  - Any other byte pushes the entry {`brk`, `ext`, code[7:0]} and clears both flags in the same cycle.
- **FIFO:** circular, with read pointer, write pointer and count.
  - Push when full: the entry is dropped and the sticky `ovf` flag is set.
  - Push and pop in the same cycle: both take effect and the count is unchanged, including when the FIFO is full.
- **Response format:** `kbd_respond` = {valid, brk, ext, ovf, 4'b0, code[7:0]}.
  - Non-empty FIFO: valid=1 and the fields come from the head entry.
  - Empty FIFO: valid=0 and brk/ext/code are 0.
  - `ovf` reflects the sticky flag at the time of the read and is cleared by that read. A push that overflows in the same cycle as the read re-sets it.
- **Read handshake:**
  - A rising edge of `kbd_en` (registered `kbd_en` was 0, now 1) triggers a read:
    - latch the response into the `kbd_respond` register;
    - pop the FIFO if it is non-empty;
    - set `kbd_r_ready`.
  - While `kbd_en` stays high: `kbd_respond` is held, `kbd_r_ready` stays 1, and no further pops occur.
  - `kbd_en` low: `kbd_r_ready` goes to 0 the next cycle and `kbd_respond` goes to 0. A new read requires `kbd_en` to return low first.
- **Reset:** asserting `rst_n` low at any time, including mid-frame, forces:
  - FSM to IDLE;
  - FIFO empty;
  - `ext`, `brk` and `ovf` cleared;
  - `kbd_respond` = 16'h0000, `kbd_r_ready` = 0, `fifo_count` = 0, `frame_err` = 0;
  - synchronisers to 1 (PS/2 idle level).

## Timing
- The first `clk` edge with `kbd_en` high registers the request. `kbd_respond` and `kbd_r_ready` are valid after the following edge: 1-cycle latency, registered outputs.
- The pop and the `fifo_count` decrement are visible in the same cycle `kbd_r_ready` rises.
- From the falling edge of `ps2_clk` on the stop bit to the `fifo_count` increment: at most 4 `clk` cycles.
- `frame_err` is a single-cycle pulse, at the same latency as a push.
- `ps2_clk` is assumed ≥ 10 `clk` periods per half-cycle. Faster input is unsupported.

## Test plan
- Send frame 0x1C with correct parity, then pulse `kbd_en` for 1 cycle → `kbd_r_ready`=1 one cycle later with `kbd_respond`=16'h801C, then `fifo_count`=0.
- Send E0, F0, 74, then read → 16'hE074. A second read → 16'h0000 with `kbd_r_ready`=1.
- Send 0x1C with a flipped parity bit → one `frame_err` pulse, `fifo_count` stays 0, and a read returns 16'h0000. Then send F0 then an error frame then 1C → the read returns 16'h801C (prefix cleared).
- Send 9 frames 0x01..0x09 into depth 8. Reads in order return:
  - 16'h9001, with `ovf` cleared by that read;
  - 16'h8002 through 16'h8008;
  - 16'h0000 on the ninth read.
- Hold `kbd_en` high for 5 cycles with 2 entries queued → exactly one pop, `kbd_respond` stable, `fifo_count` 2→1. Then drop `kbd_en` → `kbd_r_ready` goes 0 the next cycle.
- Stop `ps2_clk` after 4 data bits for `TIMEOUT_CYCLES`+5 cycles, then send 0x1C → a read returns 16'h801C. Assert `rst_n` mid-frame → all outputs 0 and `fifo_count`=0.
